siso: RTL and testbench
=======================

// Module: siso
// PURPOSE
// - Serial-in/serial-out shift register: a WIDTH-stage delay line for a 1-bit serial stream.
// - Each bit on data_in leaves on data_out exactly WIDTH rising clk edges after it is sampled.
// - Generic bit-delay/alignment primitive for serial datapaths.
// - Adds a parallel debug tap and a "primed" flag. Both are optional to connect.
// PARAMETERS
// - WIDTH      4    number of register stages = latency in clk cycles; legal range 1..1024
// - RESET_VAL  '0   [WIDTH-1:0] value loaded into the stages on reset; bit i -> stage i
// PORTS
// - clk       in   1      rising-edge clock; the only clock
// - reset     in   1      asynchronous, active-high reset
// - data_in   in   1      serial input; sampled into stage 0 on each rising clk edge
// - data_out  out  1      serial output; always equals stage WIDTH-1 (registered, no comb path)
// - taps      out  WIDTH  parallel view of all stages; taps[0] is newest, taps[WIDTH-1] is oldest
// - primed    out  1      high once WIDTH edges have occurred since reset release
// BEHAVIOUR
// - Reset and clocking: one clock; reset is asynchronous and active-high.
// - Reset value: while reset=1, stages=RESET_VAL, data_out=RESET_VAL[WIDTH-1], taps=RESET_VAL, primed=0.
// - Reset assertion: outputs change immediately, without waiting for a clk edge.
// - Reset mid-stream: discards all in-flight bits; the next edge after release starts a fresh fill.
// - Shift (reset=0, each rising clk edge):
//   - stage[0] <= data_in
//   - stage[i] <= stage[i-1] for i = 1..WIDTH-1
//   - no enable; shifting happens on every edge.
// - Latency: a bit sampled at edge k is visible on data_out after edge k+WIDTH-1.
//   - That is, it is stable during the whole cycle after edge k+WIDTH-1.
//   - Example, WIDTH=4: data_in held 4 cycles is visible on data_out 4 cycles after it was applied.
// - WIDTH=1: a single flop; data_out is data_in delayed by 1 cycle.
// - Fill counter:
//   - saturating, clog2(WIDTH+1) bits; cleared by reset
//   - increments on each edge while below WIDTH
//   - primed = (count == WIDTH); the counter never wraps.
// - data_in is X or Z while reset=1: no effect on any state.
// - Elaboration: WIDTH < 1 is a $fatal error.
// - Assertions (simulation only):
//   - data_out equals data_in from WIDTH cycles earlier, checked once primed
//   - primed is 0 in the cycle after reset falls, unless WIDTH=1.
// STRUCTURE
// - No shared package required.
//   - Exception: if other serial blocks reuse it, put the localparam CNT_W = $clog2(WIDTH+1) in siso_pkg.
// - One sub-module: siso_stage. It is a 1-bit D flop with async active-high reset and a RST_VAL parameter.
//   - Instantiate it WIDTH times in a generate loop to form the chain.
// - Top level: generate chain, fill counter, primed flag, output assigns, assertions.
// TESTING
// - Reset: hold reset=1 for 2 cycles with data_in=1.
//   -> data_out=0, taps=4'b0000, primed=0 throughout.
// - Pattern 1,0,1,0, each bit held 4 cycles after reset release (WIDTH=4).
//   -> data_out sampled at the end of each 4-cycle window reads 1,0,1,0; captured word = 4'b1010.
// - Single 1-cycle pulse of 1 into a zeroed register.
//   -> data_out high for exactly 1 cycle, 4 edges later; taps walks 0001,0010,0100,1000.
// - primed: low for edges 1-3 after release, high from edge 4.
//   -> stays high indefinitely; drops within the same cycle on an async reset pulse.
// - Async reset mid-shift: taps=4'b1011, reset pulsed between edges.
//   -> taps=0000 immediately; the next bits shift in from empty.
// - Parameter sweep WIDTH=1 and WIDTH=8 with RESET_VAL=8'hA5 (random stream, 200 cycles).
//   -> reset shows data_out=1; the delay check passes at WIDTH cycles.

Source files
------------

// File: rtl/siso_pkg.sv
// siso_pkg: shared definitions for the serial delay-line family.
// Holds the legal stage-count bounds and the fill-counter width helper. Other
// serial blocks that keep a saturating "stages filled" count can reuse it.
package siso_pkg;

  // Smallest and largest supported number of register stages.
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 1024;

  // Width of a saturating counter that must reach the value 'width' exactly.
  function automatic int fill_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : siso_pkg

// File: rtl/siso_stage.sv
// siso_stage: one stage of the serial delay line.
// A 1-bit D flop with asynchronous, active-high reset to RST_VAL.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, loads RST_VAL
//   d     - next stage value
//   q     - registered stage value
module siso_stage #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : siso_stage

// File: rtl/siso.sv
// siso: serial-in/serial-out shift register, a WIDTH-stage delay line for a
// 1-bit stream. Each bit sampled on data_in appears on data_out once it has
// walked through all WIDTH stages. A parallel tap view and a "primed" flag
// (all stages hold post-reset data) are provided for debug and alignment.
// Ports:
//   clk      - rising-edge clock, the only clock
//   reset    - asynchronous active-high reset
//   data_in  - serial input, sampled into stage 0 every rising edge
//   data_out - serial output, the oldest stage (registered)
//   taps     - all stages; taps[0] newest, taps[WIDTH-1] oldest
//   primed   - high once WIDTH edges have occurred since reset release
module siso
  import siso_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  output logic             data_out,
  output logic [WIDTH-1:0] taps,
  output logic             primed
);

  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $fatal(1, "siso: WIDTH must be at least %0d", MIN_WIDTH);
  end

  localparam int             CNT_W = fill_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] stage_q;
  logic [CNT_W-1:0] fill_cnt;

  // Stage chain: stage 0 takes the serial input, every later stage takes its
  // predecessor. Built per stage so WIDTH=1 needs no special-case slicing.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_head
      assign stage_d[i] = data_in;
    end else begin : g_link
      assign stage_d[i] = stage_q[i-1];
    end

    siso_stage #(
      .RST_VAL (RESET_VAL[i])
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .d     (stage_d[i]),
      .q     (stage_q[i])
    );
  end

  // Saturating fill counter: counts edges since reset release up to WIDTH
  // and then holds, so primed never drops except on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if (fill_cnt != FULL) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  assign primed   = (fill_cnt == FULL);
  assign data_out = stage_q[WIDTH-1];
  assign taps     = stage_q;

`ifndef SYNTHESIS
  // Once every stage holds post-reset data, the output is the input from
  // exactly WIDTH edges ago.
  a_delay : assert property (
    @(posedge clk) disable iff (reset)
      primed |-> (data_out == $past(data_in, WIDTH))
  );

  // The first edge after release can only complete the fill when WIDTH=1.
  a_first_edge : assert property (
    @(posedge clk) disable iff (reset)
      ($past(reset) && !reset) |=> (primed == (WIDTH == 1))
  );
`endif

endmodule : siso

// File: tb/tb_siso.sv
module tb_siso;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_in;

  logic       dout4;
  logic [3:0] taps4;
  logic       primed4;

  logic       dout1;
  logic [0:0] taps1;
  logic       primed1;

  logic       dout8;
  logic [7:0] taps8;
  logic       primed8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  siso #(
    .WIDTH     (4),
    .RESET_VAL (4'b0000)
  ) dut4 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (dout4),
    .taps     (taps4),
    .primed   (primed4)
  );

  siso #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (dout1),
    .taps     (taps1),
    .primed   (primed1)
  );

  siso #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) dut8 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (dout8),
    .taps     (taps8),
    .primed   (primed8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard queues hold stage contents oldest-first: q[0] is data_out.
  logic q1[$];
  logic q8[$];

  initial begin
    logic [3:0] pat;
    logic [3:0] word;
    logic [3:0] seq;
    logic [3:0] walk;
    logic [7:0] rv8;
    logic [7:0] exp8;
    logic       d;
    int         edges;

    // Reset held with data_in=1: outputs forced to reset values at once.
    reset   = 1'b1;
    data_in = 1'b1;
    #1;
    check("rst_async_dout", 32'(dout4), 32'd0);
    check("rst_async_taps", 32'(taps4), 32'd0);
    check("rst_async_primed", 32'(primed4), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_hold_dout", 32'(dout4), 32'd0);
      check("rst_hold_taps", 32'(taps4), 32'd0);
      check("rst_hold_primed", 32'(primed4), 32'd0);
    end

    // Pattern 1,0,1,0 each held for 4 edges; primed tracks the fill.
    reset = 1'b0;
    pat   = 4'b1010;
    word  = '0;
    edges = 0;
    for (int w = 0; w < 4; w++) begin
      data_in = pat[3-w];
      for (int c = 0; c < 4; c++) begin
        tick();
        edges++;
        check("primed_fill", 32'(primed4), (edges >= 4) ? 32'd1 : 32'd0);
      end
      word = {word[2:0], dout4};
      check("pattern_bit", 32'(dout4), 32'(pat[3-w]));
    end
    check("pattern_word", 32'(word), 32'hA);
    check("pattern_drained", 32'(taps4), 32'd0);

    // Single-cycle pulse walks through the taps and appears once on data_out.
    data_in = 1'b1;
    tick();
    data_in = 1'b0;
    walk = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      check("pulse_taps", 32'(taps4), 32'(walk));
      check("pulse_dout", 32'(dout4), (c == 3) ? 32'd1 : 32'd0);
      check("pulse_primed", 32'(primed4), 32'd1);
      walk = walk << 1;
      tick();
    end
    check("pulse_gone_taps", 32'(taps4), 32'd0);
    check("pulse_gone_dout", 32'(dout4), 32'd0);

    // Load 1011 then pulse reset between edges.
    seq = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      data_in = seq[3-c];
      tick();
    end
    check("mid_taps", 32'(taps4), 32'hB);
    check("mid_dout", 32'(dout4), 32'd1);
    check("mid_primed", 32'(primed4), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_taps", 32'(taps4), 32'd0);
    check("mid_rst_dout", 32'(dout4), 32'd0);
    check("mid_rst_primed", 32'(primed4), 32'd0);
    #1;
    reset = 1'b0;
    data_in = 1'b1;
    tick();
    check("refill_1", 32'(taps4), 32'h1);
    check("refill_1_primed", 32'(primed4), 32'd0);
    tick();
    data_in = 1'b0;
    check("refill_2", 32'(taps4), 32'h3);
    tick();
    check("refill_3", 32'(taps4), 32'h6);
    check("refill_3_primed", 32'(primed4), 32'd0);
    tick();
    check("refill_4", 32'(taps4), 32'hC);
    check("refill_4_primed", 32'(primed4), 32'd1);

    // Sweep: WIDTH=1 (reset 1) and WIDTH=8 (reset A5), X on input in reset.
    reset   = 1'b1;
    data_in = 1'bx;
    #1;
    check("w8_rst_dout", 32'(dout8), 32'd1);
    check("w8_rst_taps", 32'(taps8), 32'hA5);
    check("w1_rst_dout", 32'(dout1), 32'd1);
    check("w8_rst_primed", 32'(primed8), 32'd0);
    check("w1_rst_primed", 32'(primed1), 32'd0);
    tick();
    check("w8_rst_x_taps", 32'(taps8), 32'hA5);
    check("w1_rst_x_dout", 32'(dout1), 32'd1);

    rv8 = 8'hA5;
    q8.delete();
    q1.delete();
    for (int i = 7; i >= 0; i--) q8.push_back(rv8[i]);
    q1.push_back(1'b1);

    reset = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      d = 1'($urandom_range(0, 1));
      data_in = d;
      q8.push_back(d);
      q1.push_back(d);
      tick();
      void'(q8.pop_front());
      void'(q1.pop_front());
      for (int i = 0; i < 8; i++) exp8[i] = q8[7-i];
      check("w8_dout", 32'(dout8), 32'(q8[0]));
      check("w8_taps", 32'(taps8), 32'(exp8));
      check("w8_primed", 32'(primed8), (n >= 8) ? 32'd1 : 32'd0);
      check("w1_dout", 32'(dout1), 32'(q1[0]));
      check("w1_primed", 32'(primed1), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_siso
